// File: rtl/ofmap_streamer.sv
// Snapshots the accelerator's pooled output map on each done rising edge and streams it out
// row-major over valid/ready with row-end and frame-end markers.
module ofmap_streamer #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned POOL_OFMAP_SIZE = 13,
  parameter int unsigned FRAME_CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   done_in,
  input  logic [DATA_WIDTH-1:0]  ofmap_in [POOL_OFMAP_SIZE][POOL_OFMAP_SIZE],
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last_row,
  output logic                   m_last_frame,
  output logic                   busy,
  output logic                   overflow,
  input  logic                   clr_overflow,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned IdxW = (POOL_OFMAP_SIZE > 1) ? $clog2(POOL_OFMAP_SIZE) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(POOL_OFMAP_SIZE - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e                 state_q, state_d;
  logic                   done_q;
  logic [IdxW-1:0]        row_q, row_d;
  logic [IdxW-1:0]        col_q, col_d;
  logic                   overflow_q, overflow_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [DATA_WIDTH-1:0]  frame_q [POOL_OFMAP_SIZE][POOL_OFMAP_SIZE];
  logic [DATA_WIDTH-1:0]  frame_d [POOL_OFMAP_SIZE][POOL_OFMAP_SIZE];

  logic capture_evt;
  logic xfer;
  logic at_last;
  logic final_xfer;
  logic load;
  logic ovf_set;

  assign capture_evt = done_in & ~done_q;
  assign at_last     = (row_q == LastIdx) && (col_q == LastIdx);
  assign xfer        = m_valid & m_ready;
  assign final_xfer  = xfer & at_last;
  // A capture is accepted when idle, or exactly on the final beat so frames run back-to-back.
  assign load        = capture_evt & ((state_q == StIdle) | final_xfer);
  assign ovf_set     = capture_evt & (state_q == StStream) & ~final_xfer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (capture_evt) state_d = StStream;
      StStream: if (final_xfer && !capture_evt) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    m_valid      = (state_q == StStream);
    busy         = (state_q == StStream);
    m_data       = m_valid ? frame_q[row_q][col_q] : '0;
    m_last_row   = m_valid && (col_q == LastIdx);
    m_last_frame = m_valid && at_last;
    overflow     = overflow_q;
    frame_cnt    = frame_cnt_q;
  end

  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    frame_d     = frame_q;

    if (load) begin
      frame_d = ofmap_in;
      row_d   = '0;
      col_d   = '0;
    end else if (xfer) begin
      if (col_q == LastIdx) begin
        col_d = '0;
        row_d = at_last ? '0 : row_q + IdxW'(1);
      end else begin
        col_d = col_q + IdxW'(1);
      end
    end

    if (final_xfer) begin
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
    end

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q      <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      done_q      <= done_in;
      row_q       <= row_d;
      col_q       <= col_d;
      overflow_q  <= overflow_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Frame buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

endmodule

// File: tb/tb_ofmap_streamer.sv
// Directed bench for ofmap_streamer: single frame, backpressure, held done, overflow,
// back-to-back frames and asynchronous reset mid-frame.
module tb_ofmap_streamer;

  localparam int N  = 13;
  localparam int DW = 8;
  localparam int FW = 16;
  localparam int FrameBeats = N * N;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          done_in = 1'b0;
  logic          m_ready = 1'b0;
  logic          clr_overflow = 1'b0;
  logic [DW-1:0] ofmap_in [N][N];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last_row;
  logic          m_last_frame;
  logic          busy;
  logic          overflow;
  logic [FW-1:0] frame_cnt;

  int         n_vec = 0;
  int         n_err = 0;
  int         exp_frames = 0;
  int         cyc;
  logic [7:0] exp_q [$];

  ofmap_streamer #(
    .DATA_WIDTH      (DW),
    .POOL_OFMAP_SIZE (N),
    .FRAME_CNT_W     (FW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .done_in      (done_in),
    .ofmap_in     (ofmap_in),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last_row   (m_last_row),
    .m_last_frame (m_last_frame),
    .busy         (busy),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) ofmap_in[i][j] = 8'(i * N + j);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) ofmap_in[i][j] = v;
  endtask

  task automatic exp_pattern();
    exp_q.delete();
    for (int k = 0; k < FrameBeats; k++) exp_q.push_back(8'(k));
  endtask

  task automatic kick();
    @(posedge clk);
    #1;
    done_in = 1'b1;
  endtask

  // Runs until nbeats transfers are seen; optionally pulses done_in (with a new ofmap fill)
  // in the cycle that carries beat pulse_beat.
  task automatic collect(input int nbeats, input bit rnd, input bit hold, input int pulse_beat,
                         input logic [7:0] pulse_fill, output int cycles);
    int         beat = 0;
    int         c = 0;
    bit         pulsed = 1'b0;
    bit         stalled = 1'b0;
    logic [7:0] held = '0;
    while (beat < nbeats && c < 4000) begin
      @(posedge clk);
      #1;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!pulsed && beat == pulse_beat) begin
        done_in = 1'b1;
        fill_const(pulse_fill);
        pulsed = 1'b1;
      end else begin
        done_in = hold;
      end
      @(negedge clk);
      c++;
      if (stalled) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, held);
      end
      stalled = m_valid && !m_ready;
      held    = m_data;
      if (m_valid && m_ready) begin
        int k;
        k = beat % FrameBeats;
        check("data", m_data, exp_q[beat]);
        check("last_row", m_last_row, (k % N) == N - 1);
        check("last_frame", m_last_frame, k == FrameBeats - 1);
        beat++;
      end
    end
    check("beat_count", beat, nbeats);
    cycles = c;
  endtask

  initial begin
    fill_pattern();
    #12;
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_data", m_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_last_row", m_last_row, 0);
    check("rst_last_frame", m_last_frame, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single frame, ready held high: first beat one cycle after capture, no bubbles.
    exp_pattern();
    kick();
    collect(FrameBeats, 1'b0, 1'b0, -1, 8'h00, cyc);
    check("t1_cycles", cyc, FrameBeats);
    exp_frames++;
    @(negedge clk);
    check("t1_frame_cnt", frame_cnt, exp_frames);
    check("t1_busy_drop", busy, 0);
    check("t1_valid_drop", m_valid, 0);

    // Random backpressure.
    kick();
    collect(FrameBeats, 1'b1, 1'b0, -1, 8'h00, cyc);
    exp_frames++;
    m_ready = 1'b1;
    @(negedge clk);
    check("t2_frame_cnt", frame_cnt, exp_frames);
    check("t2_overflow", overflow, 0);

    // done_in held high for ~500 cycles gives exactly one frame.
    kick();
    collect(FrameBeats, 1'b0, 1'b1, -1, 8'h00, cyc);
    repeat (330) @(negedge clk);
    check("t3_idle", busy, 0);
    @(posedge clk);
    #1;
    done_in = 1'b0;
    exp_frames++;
    @(negedge clk);
    check("t3_frame_cnt", frame_cnt, exp_frames);
    check("t3_overflow", overflow, 0);

    // Second capture mid-frame is dropped; buffer must stay intact.
    kick();
    collect(FrameBeats, 1'b0, 1'b0, 40, 8'h55, cyc);
    exp_frames++;
    @(negedge clk);
    check("t4_overflow_set", overflow, 1);
    check("t4_frame_cnt", frame_cnt, exp_frames);
    check("t4_busy", busy, 0);
    @(posedge clk);
    #1;
    clr_overflow = 1'b1;
    @(posedge clk);
    #1;
    clr_overflow = 1'b0;
    @(negedge clk);
    check("t4_overflow_clr", overflow, 0);

    // Back-to-back: capture on the final beat, next frame all 0xAA.
    fill_pattern();
    exp_pattern();
    for (int k = 0; k < FrameBeats; k++) exp_q.push_back(8'hAA);
    kick();
    collect(2 * FrameBeats, 1'b0, 1'b0, FrameBeats - 1, 8'hAA, cyc);
    check("t5_cycles", cyc, 2 * FrameBeats);
    exp_frames += 2;
    @(negedge clk);
    check("t5_frame_cnt", frame_cnt, exp_frames);
    check("t5_overflow", overflow, 0);
    check("t5_busy", busy, 0);

    // Asynchronous reset after beat 80, then a fresh frame.
    fill_pattern();
    exp_pattern();
    kick();
    collect(81, 1'b0, 1'b0, -1, 8'h00, cyc);
    #2;
    reset = 1'b0;
    #1;
    check("t6_valid", m_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_frame_cnt", frame_cnt, 0);
    check("t6_data", m_data, 0);
    exp_frames = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    kick();
    collect(FrameBeats, 1'b0, 1'b0, -1, 8'h00, cyc);
    check("t6_cycles", cyc, FrameBeats);
    exp_frames++;
    @(negedge clk);
    check("t6_frame_cnt_after", frame_cnt, exp_frames);
    check("t6_busy_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
